// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the 2-read/1-write register file.
package reg_file_pkg;

  // Flush engine states
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  // Number of entries for an address width of m bits
  function automatic int unsigned depth(input int unsigned m);
    return 32'd1 << m;
  endfunction

endpackage

// File: rtl/reg_file_fill_ctl.sv
// Flush sequencer: walks every entry once, writing the latched fill value.
module reg_file_fill_ctl
  import reg_file_pkg::*;
#(
  parameter int M = 2,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         flush,
  input  logic [N-1:0] fill_data,
  output logic         busy,
  output logic         fill_we,
  output logic [M-1:0] fill_addr,
  output logic [N-1:0] fill_wdata
);

  localparam logic [M-1:0] CNT_LAST = '1;

  fill_state_e  state_q, state_d;
  logic [M-1:0] cnt_q, cnt_d;
  logic [N-1:0] fill_q, fill_d;
  logic         busy_q, busy_d;

  // Next-state logic: start on flush in IDLE, step once per cycle in FILL
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FILL;
          cnt_d   = '0;
          fill_d  = fill_data;
        end
      end
      FILL: begin
        cnt_d = cnt_q + M'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == FILL);
  end

  // State registers with synchronous reset overriding any running flush
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign fill_we    = (state_q == FILL);
  assign fill_addr  = cnt_q;
  assign fill_wdata = fill_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file: two async read ports, one sync write port, sequenced flush.
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle writes to the read ports.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int M = 2,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         writeEnable,
  input  logic [M-1:0] writeAddr,
  input  logic [N-1:0] dataIn,
  input  logic [M-1:0] readAddrA,
  output logic [N-1:0] dataOutA,
  input  logic [M-1:0] readAddrB,
  output logic [N-1:0] dataOutB,
  input  logic         flush,
  input  logic [N-1:0] fillData,
  output logic         busy,
  output logic         writeAck
);

  localparam int DEPTH = depth(M);

  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] mem_d [DEPTH];
  logic         write_ack_q, write_ack_d;
  logic         user_we;
  logic         fill_we;
  logic [M-1:0] fill_addr;
  logic [N-1:0] fill_wdata;

  reg_file_fill_ctl #(
    .M(M),
    .N(N)
  ) u_fill_ctl (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .fill_data (fillData),
    .busy      (busy),
    .fill_we   (fill_we),
    .fill_addr (fill_addr),
    .fill_wdata(fill_wdata)
  );

  // User writes commit only when idle and not colliding with a flush request
  assign user_we = writeEnable && !flush && !fill_we;

  // Write mux: fill engine and user port are mutually exclusive by state
  always_comb begin
    mem_d = mem_q;
    if (fill_we) begin
      mem_d[fill_addr] = fill_wdata;
    end else if (user_we) begin
      mem_d[writeAddr] = dataIn;
    end
    write_ack_d = user_we;
  end

  // Storage and acknowledge registers
  always_ff @(posedge clk) begin
    if (clr) begin
      mem_q       <= '{default: '0};
      write_ack_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      write_ack_q <= write_ack_d;
    end
  end

  assign writeAck = write_ack_q;

  // Read ports
`ifdef REG_FILE_BYPASS_EN
  always_comb begin
    dataOutA = mem_q[readAddrA];
    dataOutB = mem_q[readAddrB];
    if (fill_we && (fill_addr == readAddrA)) begin
      dataOutA = fill_wdata;
    end else if (user_we && (writeAddr == readAddrA)) begin
      dataOutA = dataIn;
    end
    if (fill_we && (fill_addr == readAddrB)) begin
      dataOutB = fill_wdata;
    end else if (user_we && (writeAddr == readAddrB)) begin
      dataOutB = dataIn;
    end
  end
`else
  always_comb begin
    dataOutA = mem_q[readAddrA];
    dataOutB = mem_q[readAddrB];
  end
`endif

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w with a behavioural reference model.
module tb_reg_file_2r1w;

  localparam int M = 2;
  localparam int N = 16;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         writeEnable = 1'b0;
  logic [M-1:0] writeAddr = '0;
  logic [N-1:0] dataIn = '0;
  logic [M-1:0] readAddrA = '0;
  logic [N-1:0] dataOutA;
  logic [M-1:0] readAddrB = '0;
  logic [N-1:0] dataOutB;
  logic         flush = 1'b0;
  logic [N-1:0] fillData = '0;
  logic         busy;
  logic         writeAck;

  always #5 clk = ~clk;

  reg_file_2r1w #(.M(M), .N(N)) dut (
    .clk(clk), .clr(clr), .writeEnable(writeEnable), .writeAddr(writeAddr),
    .dataIn(dataIn), .readAddrA(readAddrA), .dataOutA(dataOutA),
    .readAddrB(readAddrB), .dataOutB(dataOutB), .flush(flush),
    .fillData(fillData), .busy(busy), .writeAck(writeAck)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         ack;
    bit           chk;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit done = 1'b0;
  int cyc = 0;

  // Reference model state
  logic [N-1:0] m_mem [DEPTH];
  bit           m_fill;
  int           m_idx;
  logic [N-1:0] m_val;
  logic         m_ack;

  function automatic logic [N-1:0] model_read(input logic [M-1:0] ra, input logic we,
                                              input logic [M-1:0] wa, input logic [N-1:0] din,
                                              input logic fl);
    logic [N-1:0] r;
    r = m_mem[ra];
`ifdef REG_FILE_BYPASS_EN
    if (m_fill && m_idx == int'(ra)) r = m_val;
    else if (!m_fill && we && !fl && wa == ra) r = din;
`endif
    return r;
  endfunction

  // Apply one cycle of inputs, record the expected outputs, advance the model
  task automatic cycle(input logic c, input logic we, input logic [M-1:0] wa,
                       input logic [N-1:0] din, input logic [M-1:0] ra,
                       input logic [M-1:0] rb, input logic fl, input logic [N-1:0] fd,
                       input bit chk);
    exp_t e;
    @(negedge clk);
    clr = c; writeEnable = we; writeAddr = wa; dataIn = din;
    readAddrA = ra; readAddrB = rb; flush = fl; fillData = fd;
    e.a = model_read(ra, we, wa, din, fl);
    e.b = model_read(rb, we, wa, din, fl);
    e.busy = m_fill;
    e.ack = m_ack;
    e.chk = chk;
    e.cyc = cyc;
    sb.push_back(e);
    cyc++;
    if (c) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_fill = 0; m_idx = 0; m_ack = 0;
    end else if (m_fill) begin
      m_mem[m_idx] = m_val;
      m_idx++;
      if (m_idx == DEPTH) m_fill = 0;
      m_ack = 0;
    end else if (fl) begin
      m_fill = 1; m_idx = 0; m_val = fd; m_ack = 0;
    end else if (we) begin
      m_mem[wa] = din;
      m_ack = 1;
    end else begin
      m_ack = 0;
    end
  endtask

  task automatic idle(input logic [M-1:0] ra, input logic [M-1:0] rb);
    cycle(1'b0, 1'b0, '0, '0, ra, rb, 1'b0, '0, 1'b1);
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req, input int c);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, req);
    end
  endtask

  // Driver: directed test-plan sequences followed by random traffic
  task automatic driver();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_fill = 0; m_idx = 0; m_val = '0; m_ack = 0;
    cycle(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) idle(M'(i), M'(DEPTH - 1 - i));
    // basic write and dual read
    cycle(1'b0, 1'b1, 2'd2, 16'hBEEF, 2'd0, 2'd1, 1'b0, '0, 1'b1);
    idle(2'd2, 2'd2);
    idle(2'd2, 2'd2);
    // flush with a dropped write during busy
    cycle(1'b0, 1'b0, '0, '0, 2'd0, 2'd1, 1'b1, 16'h00A5, 1'b1);
    idle(2'd0, 2'd1);
    cycle(1'b0, 1'b1, 2'd1, 16'h7777, 2'd1, 2'd2, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 2'd1, 2'd2, 1'b1, 16'h0F0F, 1'b1);
    idle(2'd3, 2'd1);
    idle(2'd3, 2'd1);
    idle(2'd1, 2'd0);
    // flush/write collision
    cycle(1'b0, 1'b1, 2'd0, 16'h1234, 2'd0, 2'd0, 1'b1, 16'h0C0C, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) idle(2'd0, M'(i));
    // reset on the 2nd FILL cycle, then a normal write
    cycle(1'b0, 1'b0, '0, '0, 2'd0, 2'd3, 1'b1, 16'h3C3C, 1'b1);
    idle(2'd0, 2'd1);
    cycle(1'b1, 1'b0, '0, '0, 2'd0, 2'd1, 1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) idle(M'(i), M'(i));
    cycle(1'b0, 1'b1, 2'd3, 16'h5555, 2'd3, 2'd3, 1'b0, '0, 1'b1);
    idle(2'd3, 2'd0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), M'($urandom),
            N'($urandom), M'($urandom), M'($urandom), ($urandom_range(0, 7) == 0),
            N'($urandom), 1'b1);
    end
    idle(2'd0, 2'd0);
    done = 1'b1;
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle
  task automatic monitor();
    exp_t e;
    int budget;
    budget = 0;
    while (!(done && sb.size() == 0)) begin
      @(negedge clk);
      #3;
      budget++;
      if (budget > 5000) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout: scoreboard not drained, %0d left", sb.size());
        break;
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          check("dataOutA", dataOutA, e.a, e.cyc);
          check("dataOutB", dataOutB, e.b, e.cyc);
          check("busy", N'(busy), N'(e.busy), e.cyc);
          check("writeAck", N'(writeAck), N'(e.ack), e.cyc);
        end
      end
    end
  endtask

  initial begin
    fork
      driver();
      monitor();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
